// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
//
// Serial pattern transmitter. Accepts a parallel pattern word, a bit length
// and a repeat count through a valid/ready load port, then shifts the pattern
// out MSB-first (bit len-1 first, bit 0 last) one bit per clock. Repeated
// passes are bit-contiguous. A one-cycle done pulse follows the final bit.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   load_valid   in   load request
//   load_ready   out  load can be accepted this cycle
//   load_data    in   [WIDTH-1:0] pattern word
//   load_len     in   [LEN_W-1:0] bits to send (0 legal, >WIDTH clamped)
//   load_repeat  in   [REP_W-1:0] extra passes (total = load_repeat+1)
//   out          out  serial bit (registered), IDLE_BIT when not valid
//   out_valid    out  out carries a pattern bit (registered)
//   busy         out  transfer in progress (state != IDLE)
//   done         out  one-cycle pulse after the final bit (registered)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a load, load_ready high
// S_SHIFT | a pattern bit is on out; bit_cnt_q counts bits left in pass
// S_DONE  | done pulse cycle, returns to IDLE next

module seq_pattern_tx #(
  parameter int   WIDTH    = 16,
  parameter int   LEN_W    = 5,
  parameter int   REP_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_repeat,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;          // bits still to send after the one on out
  logic [WIDTH-1:0] shadow_q, shadow_d;  // original pattern for repeat passes
  logic [LEN_W-1:0] len_q, len_d;        // clamped pattern length
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_in;
  logic             accept;

  // Selects bit n-1 of the window. Written as a compare loop so the index
  // never needs a width conversion between LEN_W and the vector range.
  function automatic logic pick_bit(input logic [WIDTH-1:0] v,
                                    input logic [LEN_W-1:0] n);
    logic r;
    r = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (n == LEN_W'(i + 1)) r = v[i];
    end
    return r;
  endfunction

  assign len_in     = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
  assign load_ready = (state_q == S_IDLE) && !reset;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    shadow_d    = shadow_q;
    len_d       = len_q;
    bit_cnt_d   = bit_cnt_q;
    rep_d       = rep_q;
    out_d       = IDLE_BIT;
    out_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shadow_d  = load_data;
          len_d     = len_in;
          bit_cnt_d = len_in;
          rep_d     = load_repeat;
          if (len_in == '0) begin
            // Empty pattern: straight to the done pulse, repeats ignored.
            state_d = S_DONE;
            done_d  = 1'b1;
            sr_d    = load_data;
          end else begin
            // First bit is registered onto out at the accept edge so it
            // appears in the very next cycle.
            state_d     = S_SHIFT;
            out_d       = pick_bit(load_data, len_in);
            out_valid_d = 1'b1;
            sr_d        = load_data << 1;
          end
        end
      end

      S_SHIFT: begin
        // The <= also covers an impossible zero count so it cannot wrap.
        if (bit_cnt_q <= LEN_W'(1)) begin
          if (rep_q != '0) begin
            // Restart from the shadow copy with no gap between passes.
            out_d       = pick_bit(shadow_q, len_q);
            out_valid_d = 1'b1;
            sr_d        = shadow_q << 1;
            bit_cnt_d   = len_q;
            rep_d       = rep_q - REP_W'(1);
          end else begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            bit_cnt_d = '0;
          end
        end else begin
          out_d       = pick_bit(sr_q, len_q);
          out_valid_d = 1'b1;
          sr_d        = sr_q << 1;
          bit_cnt_d   = bit_cnt_q - LEN_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      shadow_q    <= '0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      rep_q       <= '0;
      out_q       <= IDLE_BIT;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      shadow_q    <= shadow_d;
      len_q       <= len_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_q       <= rep_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int REP_W = 4;
  localparam logic IDLE_BIT = 1'b0;

  logic             clk;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic [REP_W-1:0] load_repeat;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  seq_pattern_tx #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .IDLE_BIT(IDLE_BIT)
  ) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .load_repeat(load_repeat),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Drives one load, then checks the
  // serial stream (expected bits in exp, MSB = first bit sent), done timing
  // and the 1101 hit count seen by a reference overlapping detector.
  task automatic do_xfer(input string tag, input logic [WIDTH-1:0] data,
                         input logic [LEN_W-1:0] len, input logic [REP_W-1:0] rep,
                         input logic [63:0] exp, input int nbits, input int exp_hits);
    logic [3:0] hist;
    int hits;
    hist = 4'b0;
    hits = 0;
    chk1({tag, " ready_before"}, load_ready, 1'b1);
    load_data   = data;
    load_len    = len;
    load_repeat = rep;
    load_valid  = 1'b1;
    @(negedge clk);
    // Inputs change after the accept edge and must not disturb the transfer.
    load_valid  = 1'b0;
    load_data   = ~data;
    load_len    = 5'd3;
    load_repeat = 4'd7;
    for (int k = 0; k < nbits; k++) begin
      chk1($sformatf("%s valid[%0d]", tag, k), out_valid, 1'b1);
      chk1($sformatf("%s bit[%0d]", tag, k), out, exp[nbits-1-k]);
      chk1($sformatf("%s busy[%0d]", tag, k), busy, 1'b1);
      chk1($sformatf("%s done_low[%0d]", tag, k), done, 1'b0);
      hist = {hist[2:0], out};
      if (out_valid && hist == 4'b1101) hits++;
      @(negedge clk);
    end
    chk1({tag, " done_pulse"}, done, 1'b1);
    chk1({tag, " valid_after"}, out_valid, 1'b0);
    chk1({tag, " out_idle"}, out, IDLE_BIT);
    chk1({tag, " busy_done"}, busy, 1'b1);
    chk1({tag, " ready_done"}, load_ready, 1'b0);
    @(negedge clk);
    chk1({tag, " done_end"}, done, 1'b0);
    chk1({tag, " busy_end"}, busy, 1'b0);
    chk1({tag, " ready_end"}, load_ready, 1'b1);
    chkn({tag, " hits"}, hits, exp_hits);
  endtask

  initial begin
    logic saw_done;
    logic [3:0] pat_b;
    reset       = 1'b1;
    load_valid  = 1'b0;
    load_data   = '0;
    load_len    = '0;
    load_repeat = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst out", out, IDLE_BIT);
    chk1("rst out_valid", out_valid, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst done", done, 1'b0);
    chk1("rst load_ready", load_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk1("post_rst load_ready", load_ready, 1'b1);

    // 1101, single pass
    do_xfer("p1101", 16'h000D, 5'd4, 4'd0, 64'hD, 4, 1);

    // 13-bit pattern MSB-first
    do_xfer("p13", 16'b0001101100101101, 5'd13, 4'd0,
            64'b1101100101101, 13, 2);

    // 1101 with two repeats: contiguous 110111011101
    do_xfer("rep2", 16'h000D, 5'd4, 4'd2, 64'hDDD, 12, 3);

    // Length zero: done at E+1, no valid bits
    do_xfer("len0", 16'hFFFF, 5'd0, 4'd5, 64'h0, 0, 0);

    // Length 20 clamps to 16, starting at bit 15
    do_xfer("len20", 16'hA5C3, 5'd20, 4'd0, 64'hA5C3, 16, 0);

    // Window selection ignores bits above len-1
    do_xfer("len5", 16'hFFF3, 5'd5, 4'd0, 64'b10011, 5, 0);

    // Held load_valid during SHIFT: new data waits for the first IDLE cycle
    chk1("hold ready0", load_ready, 1'b1);
    load_data   = 16'h000D;
    load_len    = 5'd4;
    load_repeat = 4'd0;
    load_valid  = 1'b1;
    @(negedge clk);
    load_data = 16'h000A;
    pat_b = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      chk1($sformatf("hold A bit[%0d]", k), out, pat_b[3-k]);
      chk1($sformatf("hold A valid[%0d]", k), out_valid, 1'b1);
      chk1($sformatf("hold A ready[%0d]", k), load_ready, 1'b0);
      @(negedge clk);
    end
    chk1("hold done", done, 1'b1);
    chk1("hold ready_in_done", load_ready, 1'b0);
    @(negedge clk);
    chk1("hold idle ready", load_ready, 1'b1);
    chk1("hold idle valid", out_valid, 1'b0);
    @(negedge clk);
    load_valid = 1'b0;
    pat_b = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      chk1($sformatf("hold B bit[%0d]", k), out, pat_b[3-k]);
      chk1($sformatf("hold B valid[%0d]", k), out_valid, 1'b1);
      @(negedge clk);
    end
    chk1("hold B done", done, 1'b1);
    @(negedge clk);
    chk1("hold B ready_end", load_ready, 1'b1);

    // Reset pulse on the third bit of 10110110
    load_data   = 16'h00B6;
    load_len    = 5'd8;
    load_repeat = 4'd1;
    load_valid  = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    chk1("rstmid bit0", out, 1'b1);
    @(negedge clk);
    chk1("rstmid bit1", out, 1'b0);
    @(negedge clk);
    chk1("rstmid bit2", out, 1'b1);
    chk1("rstmid valid2", out_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk1("rstmid out", out, IDLE_BIT);
    chk1("rstmid out_valid", out_valid, 1'b0);
    chk1("rstmid done", done, 1'b0);
    chk1("rstmid busy", busy, 1'b0);
    chk1("rstmid ready_in_reset", load_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk1("rstmid ready_after", load_ready, 1'b1);
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done || out_valid) saw_done = 1'b1;
      @(negedge clk);
    end
    chk1("rstmid no_done_or_bits", saw_done, 1'b0);

    // A normal transfer still works after the abandoned one
    do_xfer("after_rst", 16'h0006, 5'd3, 4'd1, 64'b110110, 6, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
